lc3_mem_arbiter: RTL and testbench

Two-requester arbiter for the single LC-3 memory port. The LC-3 core's memory bus (`rd`/`addr`/`din`/`dout`/`complete`) and a DMA/IO requester share one memory. The block grants the memory to one requester at a time using round-robin, and latches that requester's command for the whole access. It then returns read data with a one-cycle done pulse, and aborts any access whose `complete` never arrives.

---
 rtl/lc3_mem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter
// Round-robin arbiter that shares one LC-3 memory port between the core bus
// and a DMA/IO requester. The winning command is latched for the whole
// access, read data comes back with a one-cycle done pulse on the owner's
// side, and an access that never sees mem_complete is aborted after TIMEOUT
// cycles with 16'hFFFF returned and a sticky err flag set.
//
// Handshake: a requester raises *_req and holds rd/addr/din stable until it
// is granted (request is only looked at in IDLE). The grant is implicit; the
// requester learns the outcome from its *_done pulse, which is qualified by
// *_dout being valid in the same cycle. Memory sees mem_en high for the whole
// ACCESS phase and answers with a single mem_complete cycle; mem_complete
// outside ACCESS has no effect.
module lc3_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  // core requester
  input  logic        core_req,
  input  logic        core_rd,
  input  logic [15:0] core_addr,
  input  logic [15:0] core_din,
  output logic [15:0] core_dout,
  output logic        core_done,
  // DMA requester
  input  logic        dma_req,
  input  logic        dma_rd,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_din,
  output logic [15:0] dma_dout,
  output logic        dma_done,
  // memory port
  output logic        mem_en,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_complete,
  // status
  output logic        owner,
  output logic        err,
  input  logic        err_clr,
  // FSM state for observation: 0 = IDLE, 1 = ACCESS, 2 = RESP
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic        SEL_CORE = 1'b0;
  localparam logic        SEL_DMA  = 1'b1;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        mem_rd_q, mem_rd_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_din_q, mem_din_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] core_dout_q, core_dout_d;
  logic [15:0] dma_dout_q, dma_dout_d;
  logic        err_q, err_d;

  logic        any_req;
  logic        winner;
  logic        complete_hit;
  logic        timeout_hit;

  // Arbitration and ACCESS-phase event decode
  always_comb begin
    any_req = core_req | dma_req;
    if (core_req && dma_req) begin
      // tie: the side that did not win last time goes now
      winner = ~last_q;
    end else if (dma_req) begin
      winner = SEL_DMA;
    end else begin
      winner = SEL_CORE;
    end
    complete_hit = (state_q == S_ACCESS) && mem_complete;
    // complete on the final allowed cycle beats the abort
    timeout_hit  = (state_q == S_ACCESS) && !mem_complete && (cnt_q == CNT_LAST);
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (complete_hit || timeout_hit) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs decoded from state and the latched owner only
  always_comb begin
    mem_en    = (state_q == S_ACCESS);
    core_done = (state_q == S_RESP) && (owner_q == SEL_CORE);
    dma_done  = (state_q == S_RESP) && (owner_q == SEL_DMA);
    dbg_state = state_q;
  end

  // Datapath next-state: command latch, counter, read-data returns, err
  always_comb begin
    mem_rd_d    = mem_rd_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    core_dout_d = core_dout_q;
    dma_dout_d  = dma_dout_q;
    err_d       = err_q;

    if (err_clr) err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d = winner;
          last_d  = winner;
          cnt_d   = 16'h0000;
          if (winner == SEL_DMA) begin
            mem_rd_d   = dma_rd;
            mem_addr_d = dma_addr;
            mem_din_d  = dma_din;
          end else begin
            mem_rd_d   = core_rd;
            mem_addr_d = core_addr;
            mem_din_d  = core_din;
          end
        end
      end
      S_ACCESS: begin
        if (complete_hit) begin
          // writes leave the owner's read data untouched
          if (mem_rd_q) begin
            if (owner_q == SEL_DMA) dma_dout_d = mem_dout;
            else                    core_dout_d = mem_dout;
          end
        end else if (timeout_hit) begin
          if (owner_q == SEL_DMA) dma_dout_d = 16'hFFFF;
          else                    core_dout_d = 16'hFFFF;
          // set takes priority over a same-cycle clear
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_din_q   <= 16'h0000;
      owner_q     <= SEL_CORE;
      last_q      <= SEL_DMA;
      cnt_q       <= 16'h0000;
      core_dout_q <= 16'h0000;
      dma_dout_q  <= 16'h0000;
      err_q       <= 1'b0;
    end else begin
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      core_dout_q <= core_dout_d;
      dma_dout_q  <= dma_dout_d;
      err_q       <= err_d;
    end
  end

  // Registered outputs
  always_comb begin
    mem_rd    = mem_rd_q;
    mem_addr  = mem_addr_q;
    mem_din   = mem_din_q;
    owner     = owner_q;
    core_dout = core_dout_q;
    dma_dout  = dma_dout_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter (TIMEOUT = 4).
module tb_lc3_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        core_req, core_rd;
  logic [15:0] core_addr, core_din, core_dout;
  logic        core_done;
  logic        dma_req, dma_rd;
  logic [15:0] dma_addr, dma_din, dma_dout;
  logic        dma_done;
  logic        mem_en, mem_rd;
  logic [15:0] mem_addr, mem_din, mem_dout;
  logic        mem_complete;
  logic        owner, err, err_clr;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fail;

  lc3_mem_arbiter #(.TIMEOUT(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .core_req     (core_req),
    .core_rd      (core_rd),
    .core_addr    (core_addr),
    .core_din     (core_din),
    .core_dout    (core_dout),
    .core_done    (core_done),
    .dma_req      (dma_req),
    .dma_rd       (dma_rd),
    .dma_addr     (dma_addr),
    .dma_din      (dma_din),
    .dma_dout     (dma_dout),
    .dma_done     (dma_done),
    .mem_en       (mem_en),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout),
    .mem_complete (mem_complete),
    .owner        (owner),
    .err          (err),
    .err_clr      (err_clr),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // advance one cycle; inputs are driven and outputs sampled 1 ns after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check1 (tag, mem_en, 1'b0);
    check1 (tag, mem_rd, 1'b0);
    check16(tag, mem_addr, 16'h0000);
    check16(tag, mem_din, 16'h0000);
    check1 (tag, core_done, 1'b0);
    check1 (tag, dma_done, 1'b0);
    check16(tag, core_dout, 16'h0000);
    check16(tag, dma_dout, 16'h0000);
    check1 (tag, owner, 1'b0);
    check1 (tag, err, 1'b0);
    check16(tag, {14'd0, dbg_state}, 16'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    core_req = 1'b0; core_rd = 1'b0; core_addr = 16'h0; core_din = 16'h0;
    dma_req  = 1'b0; dma_rd  = 1'b0; dma_addr  = 16'h0; dma_din  = 16'h0;
    mem_dout = 16'h0; mem_complete = 1'b0; err_clr = 1'b0;

    // ---- reset values
    tick();
    tick();
    check_reset_outputs("reset_init");
    reset = 1'b1;
    tick();

    // ---- both requesters held high: core, DMA, core, DMA
    core_req = 1'b1; core_rd = 1'b1; core_addr = 16'h1000;
    dma_req  = 1'b1; dma_rd  = 1'b1; dma_addr  = 16'h2000;
    mem_complete = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();  // ACCESS
      mem_dout = 16'hA000 + 16'(i);
      check1 ("rr_mem_en", mem_en, 1'b1);
      check1 ("rr_owner", owner, i[0]);
      check16("rr_addr", mem_addr, i[0] ? 16'h2000 : 16'h1000);
      tick();  // RESP
      check1 ("rr_core_done", core_done, ~i[0]);
      check1 ("rr_dma_done", dma_done, i[0]);
      check1 ("rr_resp_mem_en", mem_en, 1'b0);
      if (i[0]) check16("rr_dma_dout", dma_dout, 16'hA000 + 16'(i));
      else      check16("rr_core_dout", core_dout, 16'hA000 + 16'(i));
      if (i == 3) begin
        core_req = 1'b0;
        dma_req  = 1'b0;
      end
      tick();  // IDLE
      check1("rr_idle_done", core_done | dma_done, 1'b0);
    end
    mem_complete = 1'b0;

    // ---- core-only read, complete in first ACCESS cycle
    core_req = 1'b1; core_rd = 1'b1; core_addr = 16'h3000;
    tick();
    check1 ("rd_mem_en", mem_en, 1'b1);
    check16("rd_mem_addr", mem_addr, 16'h3000);
    check1 ("rd_mem_rd", mem_rd, 1'b1);
    core_req = 1'b0; mem_complete = 1'b1; mem_dout = 16'h1234;
    tick();
    check1 ("rd_core_done", core_done, 1'b1);
    check16("rd_core_dout", core_dout, 16'h1234);
    check1 ("rd_dma_done", dma_done, 1'b0);
    check16("rd_dma_dout_hold", dma_dout, 16'hA003);
    mem_complete = 1'b0;
    tick();
    check1 ("rd_done_single", core_done, 1'b0);
    check16("rd_core_dout_hold", core_dout, 16'h1234);

    // ---- DMA write, core requests mid-access with changing inputs
    dma_req = 1'b1; dma_rd = 1'b0; dma_addr = 16'h4000; dma_din = 16'hBEEF;
    tick();
    check1 ("wr_owner", owner, 1'b1);
    check1 ("wr_mem_rd", mem_rd, 1'b0);
    check16("wr_mem_din", mem_din, 16'hBEEF);
    dma_req = 1'b0;
    core_req = 1'b1; core_rd = 1'b0; core_addr = 16'h5555; core_din = 16'h1111;
    tick();
    check16("wr_hold_addr1", mem_addr, 16'h4000);
    check16("wr_hold_din1", mem_din, 16'hBEEF);
    core_addr = 16'h6666;
    tick();
    check16("wr_hold_addr2", mem_addr, 16'h4000);
    check16("wr_hold_din2", mem_din, 16'hBEEF);
    check1 ("wr_hold_owner", owner, 1'b1);
    mem_complete = 1'b1; mem_dout = 16'hDEAD;
    tick();
    check1 ("wr_dma_done", dma_done, 1'b1);
    check1 ("wr_core_done", core_done, 1'b0);
    check16("wr_dma_dout_unch", dma_dout, 16'hA003);
    mem_complete = 1'b0;
    tick();  // IDLE, core still requesting
    tick();  // ACCESS for core
    check1 ("wr_core_granted", owner, 1'b1 ^ 1'b1);
    check16("wr_core_addr", mem_addr, 16'h6666);
    check16("wr_core_din", mem_din, 16'h1111);
    core_req = 1'b0; mem_complete = 1'b1;
    tick();
    check1 ("wr_core_done2", core_done, 1'b1);
    check16("wr_core_dout_unch", core_dout, 16'h1234);
    mem_complete = 1'b0;
    tick();

    // ---- timeout: complete never arrives
    core_req = 1'b1; core_rd = 1'b1; core_addr = 16'h7000;
    tick();
    core_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check1("to_mem_en", mem_en, 1'b1);
      check1("to_no_done", core_done, 1'b0);
      tick();
    end
    check1 ("to_mem_en_drop", mem_en, 1'b0);
    check1 ("to_core_done", core_done, 1'b1);
    check16("to_core_dout", core_dout, 16'hFFFF);
    check1 ("to_err", err, 1'b1);
    tick();
    check1 ("to_err_sticky", err, 1'b1);
    check1 ("to_done_single", core_done, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check1 ("to_err_clr", err, 1'b0);

    // ---- complete on the 4th (final) ACCESS cycle wins
    core_req = 1'b1;
    tick();
    core_req = 1'b0;
    tick();
    tick();
    tick();
    check1("last_mem_en", mem_en, 1'b1);
    mem_complete = 1'b1; mem_dout = 16'h5A5A;
    tick();
    check1 ("last_core_done", core_done, 1'b1);
    check16("last_core_dout", core_dout, 16'h5A5A);
    check1 ("last_no_err", err, 1'b0);
    mem_complete = 1'b0;
    tick();

    // ---- reset in the middle of an access
    dma_req = 1'b1; dma_rd = 1'b1; dma_addr = 16'h8000;
    tick();
    check1("rst_pre_mem_en", mem_en, 1'b1);
    dma_req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check1("rst_async_mem_en", mem_en, 1'b0);
    check_reset_outputs("rst_mid");
    tick();
    check1("rst_no_done", core_done | dma_done, 1'b0);
    core_req = 1'b1; core_addr = 16'h9000;
    dma_req  = 1'b1; dma_addr  = 16'hA000;
    reset = 1'b1;
    tick();
    check1 ("rst_core_first", owner, 1'b0);
    check16("rst_core_addr", mem_addr, 16'h9000);
    core_req = 1'b0; dma_req = 1'b0; mem_complete = 1'b1; mem_dout = 16'h0F0F;
    tick();
    check1 ("rst_core_done", core_done, 1'b1);
    check16("rst_core_dout", core_dout, 16'h0F0F);
    mem_complete = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
